// File: rtl/typedef_pkg.sv
// -----------------------------------------------------------------------------
// typedef_pkg
//   Shared types for the RV32M multiply/divide execution unit.
//   - muldiv_op_e   : RV32M funct3 encodings
//   - div_state_e   : iterative divider FSM states
//   - MULDIV_OPCODE / MULDIV_FUNCT7 : OP major opcode and the M-extension funct7,
//                     used by the decoder/dispatcher to route work to this unit
// -----------------------------------------------------------------------------
package typedef_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   localparam logic [6:0] MULDIV_OPCODE = 7'b0110011;
   localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/radix2_divider.sv
// -----------------------------------------------------------------------------
// radix2_divider
//   Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU.
//   Handshake: start is sampled only in IDLE; busy is high in every other
//   state; done is high in DONE and the result is held there until ack is
//   seen. flush returns the FSM to IDLE from any state.
//   Ports:
//     clk, rst (async, active-low), flush
//     start, op, dividend, divisor : operation request
//     ack                          : result taken by the writeback port
//     busy, done                   : occupancy / result ready
//     quotient, remainder          : final values, valid while done=1
//     state                        : current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module radix2_divider
   import typedef_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  start,
   input  muldiv_op_e            op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  ack,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output div_state_e            state
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH - 1);
   localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  quo_q, quo_d;      // dividend shifts out, quotient shifts in
   logic [W-1:0]  rem_q, rem_d;      // partial remainder
   logic [W-1:0]  dsr_q, dsr_d;      // |divisor|
   logic          neg_quo_q, neg_quo_d;
   logic          neg_rem_q, neg_rem_d;

   logic          is_signed;
   logic          div_zero;
   logic          sgn_ovf;
   logic [W-1:0]  abs_dividend;
   logic [W-1:0]  abs_divisor;
   logic [W:0]    shifted;
   logic          fits;
   logic [W-1:0]  diff;

   always_comb begin
      is_signed    = (op == OP_DIV) || (op == OP_REM);
      div_zero     = (divisor == '0);
      sgn_ovf      = is_signed && (dividend == MOST_NEG) && (divisor == '1);
      abs_dividend = (is_signed && dividend[W-1]) ? -dividend : dividend;
      abs_divisor  = (is_signed && divisor[W-1])  ? -divisor  : divisor;
      // Restoring step: the true difference is below |divisor| whenever it
      // is kept, so a W-bit subtraction is exact in that case.
      shifted      = {rem_q, quo_q[W-1]};
      fits         = (shifted >= {1'b0, dsr_q});
      diff         = shifted[W-1:0] - dsr_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dsr_d     = dsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (div_zero) begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  state_d = DONE;
               end else if (sgn_ovf) begin
                  quo_d   = dividend;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  quo_d     = abs_dividend;
                  rem_d     = '0;
                  dsr_d     = abs_divisor;
                  neg_quo_d = is_signed && (dividend[W-1] ^ divisor[W-1]);
                  neg_rem_d = is_signed && dividend[W-1];
                  cnt_d     = CNT_INIT;
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            if (fits) begin
               rem_d = diff;
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = shifted[W-1:0];
               quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (neg_quo_q) begin
               quo_d = -quo_q;
            end
            if (neg_rem_q) begin
               rem_d = -rem_q;
            end
            state_d = DONE;
         end
         DONE: begin
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dsr_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dsr_q     <= dsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign state     = state_q;

endmodule

// File: rtl/muldiv_exec_unit.sv
// -----------------------------------------------------------------------------
// muldiv_exec_unit
//   RV32M multiply/divide functional unit for the out-of-order execute stage.
//   Multiplies run through a MUL_STAGES-deep pipeline (one issue per cycle);
//   divides/remainders run on radix2_divider. A single tagged writeback port
//   is shared, with the multiply pipeline always taking priority.
//
//   Handshake: the issue stage presents issue_valid with the operation for one
//   cycle and it is taken that cycle; there is no back-pressure except that a
//   divide (funct3[2]=1) must not be presented while busy_div=1. result_valid
//   is a one-cycle pulse per result with no ready; result_* are 0 otherwise.
//
//   Ports:
//     clk, rst (async, active-low), flush
//     issue_valid, issue_funct3, issue_rob_id, issue_rd_phy, rs1_data, rs2_data
//     busy_div
//     result_valid, result, result_rob_id, result_rd_phy
// -----------------------------------------------------------------------------
module muldiv_exec_unit
   import typedef_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ROB_WIDTH  = 5,
   parameter int PHY_WIDTH  = 6,
   parameter int MUL_STAGES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  issue_valid,
   input  logic [2:0]            issue_funct3,
   input  logic [ROB_WIDTH-1:0]  issue_rob_id,
   input  logic [PHY_WIDTH-1:0]  issue_rd_phy,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   output logic                  busy_div,
   output logic                  result_valid,
   output logic [DATA_WIDTH-1:0] result,
   output logic [ROB_WIDTH-1:0]  result_rob_id,
   output logic [PHY_WIDTH-1:0]  result_rd_phy
);

   localparam int W = DATA_WIDTH;

   muldiv_op_e issue_op;
   logic       mul_issue;
   logic       div_start;

   assign issue_op  = muldiv_op_e'(issue_funct3);
   assign mul_issue = issue_valid && !issue_funct3[2] && !flush;
   assign div_start = issue_valid &&  issue_funct3[2] && !flush && !busy_div;

   // ---------------------------------------------------------------- multiply
   // Operands are widened to W+1 bits with per-op signedness, then to 2W bits;
   // the 2W-bit truncated product is exact for every signedness combination.
   logic [W:0]     mul_a;
   logic [W:0]     mul_b;
   logic [2*W-1:0] mul_a_ext;
   logic [2*W-1:0] mul_b_ext;
   logic [2*W-1:0] mul_prod;
   logic [W-1:0]   mul_sel;

   always_comb begin
      mul_a     = {(issue_op != OP_MULHU) && rs1_data[W-1], rs1_data};
      mul_b     = {((issue_op == OP_MUL) || (issue_op == OP_MULH)) && rs2_data[W-1], rs2_data};
      mul_a_ext = {{(W-1){mul_a[W]}}, mul_a};
      mul_b_ext = {{(W-1){mul_b[W]}}, mul_b};
      mul_prod  = mul_a_ext * mul_b_ext;
      mul_sel   = (issue_op == OP_MUL) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];
   end

   // The product is formed at issue and then delayed; stage i is valid in
   // cycle i+1 after issue, so the last stage lines up with MUL_STAGES.
   logic [MUL_STAGES-1:0] mul_v;
   logic [W-1:0]          mul_res [MUL_STAGES];
   logic [ROB_WIDTH-1:0]  mul_rob [MUL_STAGES];
   logic [PHY_WIDTH-1:0]  mul_rd  [MUL_STAGES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_v <= '0;
         for (int i = 0; i < MUL_STAGES; i++) begin
            mul_res[i] <= '0;
            mul_rob[i] <= '0;
            mul_rd[i]  <= '0;
         end
      end else begin
         mul_v[0]   <= mul_issue;
         mul_res[0] <= mul_sel;
         mul_rob[0] <= issue_rob_id;
         mul_rd[0]  <= issue_rd_phy;
         for (int i = 1; i < MUL_STAGES; i++) begin
            mul_v[i]   <= mul_v[i-1] && !flush;
            mul_res[i] <= mul_res[i-1];
            mul_rob[i] <= mul_rob[i-1];
            mul_rd[i]  <= mul_rd[i-1];
         end
      end
   end

   logic mul_out_v;
   assign mul_out_v = mul_v[MUL_STAGES-1];

   // ----------------------------------------------------------------- divide
   logic                 div_done;
   logic                 div_ack;
   logic [W-1:0]         div_quo;
   logic [W-1:0]         div_rem;
   div_state_e           div_state;
   logic [ROB_WIDTH-1:0] div_rob_q;
   logic [PHY_WIDTH-1:0] div_rd_q;
   logic                 div_is_rem_q;

   radix2_divider #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_divider (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .start     (div_start),
      .op        (issue_op),
      .dividend  (rs1_data),
      .divisor   (rs2_data),
      .ack       (div_ack),
      .busy      (busy_div),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem),
      .state     (div_state)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_rob_q    <= '0;
         div_rd_q     <= '0;
         div_is_rem_q <= 1'b0;
      end else if (div_start) begin
         div_rob_q    <= issue_rob_id;
         div_rd_q     <= issue_rd_phy;
         div_is_rem_q <= issue_funct3[1];
      end
   end

   // -------------------------------------------------------------- writeback
   // The divider only leaves DONE in a cycle the multiplier does not claim.
   assign div_ack = div_done && !mul_out_v && !flush;

   always_comb begin
      result_valid  = 1'b0;
      result        = '0;
      result_rob_id = '0;
      result_rd_phy = '0;
      if (!flush) begin
         if (mul_out_v) begin
            result_valid  = 1'b1;
            result        = mul_res[MUL_STAGES-1];
            result_rob_id = mul_rob[MUL_STAGES-1];
            result_rd_phy = mul_rd[MUL_STAGES-1];
         end else if (div_done) begin
            result_valid  = 1'b1;
            result        = div_is_rem_q ? div_rem : div_quo;
            result_rob_id = div_rob_q;
            result_rd_phy = div_rd_q;
         end
      end
   end

`ifndef SYNTHESIS
   div_issue_while_busy: assert property (@(posedge clk) disable iff (!rst)
      !(issue_valid && issue_funct3[2] && !flush && busy_div));
   div_done_matches_state: assert property (@(posedge clk) disable iff (!rst)
      div_done == (div_state == DONE));
`endif

endmodule

// File: tb/tb_muldiv_exec_unit.sv
module tb_muldiv_exec_unit;

   localparam int DW  = 32;
   localparam int RW  = 5;
   localparam int PW  = 6;
   localparam int MS  = 3;
   localparam int EW  = 32 + RW + PW + DW;       // {due_cycle, rob, rd, data}
   localparam int DEW = 32 + 32 + RW + PW + DW;  // {issue_cycle, ready_cycle, rob, rd, data}

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          issue_valid = 1'b0;
   logic [2:0]    issue_funct3 = '0;
   logic [RW-1:0] issue_rob_id = '0;
   logic [PW-1:0] issue_rd_phy = '0;
   logic [DW-1:0] rs1_data = '0;
   logic [DW-1:0] rs2_data = '0;
   logic          busy_div;
   logic          result_valid;
   logic [DW-1:0] result;
   logic [RW-1:0] result_rob_id;
   logic [PW-1:0] result_rd_phy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [RW-1:0] next_rob = '0;

   logic [EW-1:0]  exp_q[$];      // multiply results, in due order
   logic [DEW-1:0] div_exp_q[$];  // at most one outstanding divide

   muldiv_exec_unit #(
      .DATA_WIDTH (DW),
      .ROB_WIDTH  (RW),
      .PHY_WIDTH  (PW),
      .MUL_STAGES (MS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .issue_valid   (issue_valid),
      .issue_funct3  (issue_funct3),
      .issue_rob_id  (issue_rob_id),
      .issue_rd_phy  (issue_rd_phy),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .busy_div      (busy_div),
      .result_valid  (result_valid),
      .result        (result),
      .result_rob_id (result_rob_id),
      .result_rd_phy (result_rd_phy)
   );

   // ------------------------------------------------------ clock and cycles
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // -------------------------------------------------------- reference model
   function automatic logic [DW-1:0] ref_mul(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint sa = $signed(a);
      longint sb = $signed(b);
      longint ua = a;
      longint ub = b;
      logic [63:0] p;
      case (f3)
         3'b000:  p = sa * sb;
         3'b001:  p = sa * sb;
         3'b010:  p = sa * ub;
         default: p = ua * ub;
      endcase
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [DW-1:0] ref_div(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b, output bit special);
      longint sa = $signed(a);
      longint sb = $signed(b);
      longint ua = a;
      longint ub = b;
      logic [63:0] q;
      logic [63:0] r;
      bit sgn;
      sgn = (f3 == 3'b100) || (f3 == 3'b110);
      special = 1'b0;
      if (b == 0) begin
         q = '1;
         r = ua;
         special = 1'b1;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = ua;
         r = 0;
         special = 1'b1;
      end else if (sgn) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = ua / ub;
         r = ua % ub;
      end
      return f3[1] ? r[31:0] : q[31:0];
   endfunction

   // ------------------------------------------------------------ scoreboard
   task automatic cmp(input string name, input logic ev, input logic [DW-1:0] ed, input logic [RW-1:0] er, input logic [PW-1:0] ep);
      checks++;
      if (result_valid !== ev || result !== ed || result_rob_id !== er || result_rd_phy !== ep) begin
         errors++;
         $display("FAIL %s cycle %0d: got valid=%0b data=%h rob=%0d rd=%0d, required valid=%0b data=%h rob=%0d rd=%0d",
                  name, cyc, result_valid, result, result_rob_id, result_rd_phy, ev, ed, er, ep);
      end
   endtask

   task automatic cmp_busy(input string name, input logic eb);
      checks++;
      if (busy_div !== eb) begin
         errors++;
         $display("FAIL %s cycle %0d: got busy_div=%0b, required %0b", name, cyc, busy_div, eb);
      end
   endtask

   // Monitor: each cycle the model decides what the port must show. A
   // multiply due now wins; otherwise a divide whose result is ready goes out.
   always @(negedge clk) begin
      logic [EW-1:0]  e;
      logic [DEW-1:0] d;
      logic           bexp;
      if (!rst) begin
         cmp("reset_outputs", 1'b0, '0, '0, '0);
         cmp_busy("reset_busy", 1'b0);
         exp_q.delete();
         div_exp_q.delete();
      end else begin
         bexp = (div_exp_q.size() != 0) && (int'(div_exp_q[0][DEW-1 -: 32]) < cyc);
         cmp_busy("busy_div", bexp);
         if (flush) begin
            cmp("flush_gate", 1'b0, '0, '0, '0);
            exp_q.delete();
            div_exp_q.delete();
         end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
            e = exp_q.pop_front();
            cmp("mul_result", 1'b1, e[DW-1:0], e[DW+PW+RW-1 -: RW], e[DW+PW-1 -: PW]);
         end else if (div_exp_q.size() != 0 && int'(div_exp_q[0][DEW-33 -: 32]) <= cyc) begin
            d = div_exp_q.pop_front();
            cmp("div_result", 1'b1, d[DW-1:0], d[DW+PW+RW-1 -: RW], d[DW+PW-1 -: PW]);
         end else begin
            cmp("idle_output", 1'b0, '0, '0, '0);
         end
      end
   end

   // --------------------------------------------------------------- drivers
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue_tag(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [RW-1:0] rob, input logic [PW-1:0] rd, input logic fl);
      bit special;
      logic [DW-1:0] r;
      if (f3[2] && !fl && div_exp_q.size() != 0) begin
         errors++;
         $display("FAIL protocol cycle %0d: divide issued while divider busy, required idle divider", cyc);
      end
      issue_valid  = 1'b1;
      issue_funct3 = f3;
      issue_rob_id = rob;
      issue_rd_phy = rd;
      rs1_data     = a;
      rs2_data     = b;
      flush        = fl;
      if (!fl) begin
         if (f3[2]) begin
            r = ref_div(f3, a, b, special);
            div_exp_q.push_back({32'(cyc), 32'(special ? cyc + 1 : cyc + DW + 2), rob, rd, r});
         end else begin
            exp_q.push_back({32'(cyc + MS), rob, rd, ref_mul(f3, a, b)});
         end
      end
      @(posedge clk);
      #1;
      issue_valid  = 1'b0;
      issue_funct3 = '0;
      rs1_data     = '0;
      rs2_data     = '0;
      flush        = 1'b0;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic fl);
      issue_tag(f3, a, b, next_rob, PW'($urandom_range(0, (1 << PW) - 1)), fl);
      next_rob = next_rob + RW'(1);
   endtask

   task automatic drain();
      int budget = 200;
      while ((exp_q.size() != 0 || div_exp_q.size() != 0) && budget > 0) begin
         idle(1);
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL drain cycle %0d: %0d mul and %0d div results never appeared, required 0 pending",
                  cyc, exp_q.size(), div_exp_q.size());
         exp_q.delete();
         div_exp_q.delete();
      end
   endtask

   function automatic logic [DW-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return DW'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   // ------------------------------------------------------------- stimulus
   initial begin
      logic [2:0] f3;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);

      // back-to-back multiplies
      issue_tag(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd4, 6'd10, 1'b0);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      drain();

      // signed divide / remainder
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
      drain();
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
      drain();

      // special cases
      issue(3'b101, 32'd5, 32'd0, 1'b0);
      drain();
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      drain();
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      drain();

      // multiply lands in the divider's DONE cycle
      issue(3'b101, 32'd100, 32'd7, 1'b0);
      idle(30);
      issue(3'b000, 32'd2, 32'd3, 1'b0);
      drain();

      // flush kills an in-flight divide and a same-cycle multiply
      issue(3'b100, 32'd1000, 32'd3, 1'b0);
      idle(9);
      issue(3'b000, 32'd5, 32'd5, 1'b1);
      idle(2);
      issue(3'b101, 32'd9, 32'd3, 1'b0);
      drain();

      // asynchronous reset in the middle of CALC
      issue(3'b100, 32'h1234_5678, 32'd77, 1'b0);
      idle(10);
      rst = 1'b0;
      #1;
      cmp("async_reset_outputs", 1'b0, '0, '0, '0);
      cmp_busy("async_reset_busy", 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);
      issue(3'b000, 32'd1, 32'd1, 1'b0);
      drain();

      // randomized mix
      for (int i = 0; i < 300; i++) begin
         f3 = 3'($urandom_range(0, 7));
         if (f3[2] && div_exp_q.size() != 0) f3[2] = 1'b0;
         issue(f3, rand_operand(), rand_operand(), ($urandom_range(0, 39) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
